// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file with two write ports, a PC link-write path and a per-register
// busy scoreboard for tracking in-flight producers.
//
// Register PC_REG is not stored. Reads of it return the live PC input with
// busy=0. Writes and issues that target it are dropped.
//
// Read data and busy flags are combinational. They bypass the writes and
// issues of the current cycle. Write priority, from highest to lowest, is:
// link write (PCtoBL into LINK_REG), then port 1, then port 0, then the
// stored value. The same priority decides the committed value when several
// sources hit one register.
//
// Ports
//   clk              sole clock, rising edge
//   Reset            synchronous active-high reset; clears registers and busy
//   we0/rw0/wd0      write port 0 (ALU result)
//   we1/rw1/wd1      write port 1 (memory load result)
//   PCtoBL, PC       link-write strobe and current program counter
//   ra, rb           read addresses
//   rdA, rdB         read data
//   busyA, busyB     pending-writer flags for ra / rb
//   issue_en/rd      mark issue_rd as having an in-flight producer
// ----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int LINK_REG = 14,
    parameter int PC_REG   = 15
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] rw0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] rw1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              PCtoBL,
    input  logic [DATA_W-1:0] PC,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] rdA,
    output logic [DATA_W-1:0] rdB,
    output logic              busyA,
    output logic              busyB,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;

    // Accepted sources. Anything aimed at PC_REG is dropped here, so it
    // neither writes storage nor touches a busy bit.
    logic wr0_ok, wr1_ok, lnk_ok, iss_ok;
    assign wr0_ok = we0 && (rw0 != PC_A);
    assign wr1_ok = we1 && (rw1 != PC_A);
    assign lnk_ok = PCtoBL && (LINK_A != PC_A);
    assign iss_ok = issue_en && (issue_rd != PC_A);

    // Per-register clear (accepted write) and set (new producer) masks.
    logic [NREG-1:0] clr_mask, set_mask;
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wr0_ok) clr_mask[rw0]      = 1'b1;
        if (wr1_ok) clr_mask[rw1]      = 1'b1;
        if (lnk_ok) clr_mask[LINK_A]   = 1'b1;
        if (iss_ok) set_mask[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            // Later assignments win. This ordering gives link > port 1 >
            // port 0 on an address collision.
            if (wr0_ok) regs[rw0]    <= wd0;
            if (wr1_ok) regs[rw1]    <= wd1;
            if (lnk_ok) regs[LINK_A] <= PC;
            // Set dominates clear, so a re-issue in the write cycle keeps
            // the register busy for its new producer.
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        if (a == PC_A)                 d = PC;
        else if (lnk_ok && a == LINK_A) d = PC;
        else if (wr1_ok && a == rw1)   d = wd1;
        else if (wr0_ok && a == rw0)   d = wd0;
        else                           d = regs[a];
        return d;
    endfunction

    // A register shows busy=0 when it is being written this cycle and is
    // not being re-issued in the same cycle.
    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        logic b;
        if (a == PC_A) b = 1'b0;
        else           b = busy[a] && !(clr_mask[a] && !set_mask[a]);
        return b;
    endfunction

    always_comb begin
        rdA   = read_data(ra);
        rdB   = read_data(rb);
        busyA = read_busy(ra);
        busyB = read_busy(rb);
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Bench for regfile_scoreboard in its wide configuration: 64-bit data,
// 32 registers, link register 30, PC register 31.
//
// Inputs change 1 time unit after each rising edge. Outputs are compared
// before the next edge. The reference keeps plain arrays of register values
// and busy bits. At every edge it applies the write priority and the busy
// rules register by register.
// ----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int DW  = 64;
    localparam int AW  = 5;
    localparam int NR  = 1 << AW;
    localparam int LNK = 30;
    localparam int PCR = 31;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Reset;
    logic          we0, we1, PCtoBL, issue_en;
    logic [AW-1:0] rw0, rw1, ra, rb, issue_rd;
    logic [DW-1:0] wd0, wd1, PC;
    logic [DW-1:0] rdA, rdB;
    logic          busyA, busyB;

    regfile_scoreboard #(
        .DATA_W(DW), .ADDR_W(AW), .LINK_REG(LNK), .PC_REG(PCR)
    ) dut (
        .clk(clk), .Reset(Reset),
        .we0(we0), .rw0(rw0), .wd0(wd0),
        .we1(we1), .rw1(rw1), .wd1(wd1),
        .PCtoBL(PCtoBL), .PC(PC),
        .ra(ra), .rb(rb), .rdA(rdA), .rdB(rdB),
        .busyA(busyA), .busyB(busyB),
        .issue_en(issue_en), .issue_rd(issue_rd)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_regs [NR];
    logic          m_busy [NR];

    function automatic logic [DW-1:0] exp_rd(input int a);
        if (a == PCR)                          return PC;
        if (PCtoBL && a == LNK)                return PC;
        if (we1 && int'(rw1) == a)             return wd1;
        if (we0 && int'(rw0) == a)             return wd0;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        bit written, issued;
        if (a == PCR) return 1'b0;
        written = (PCtoBL && a == LNK) || (we1 && int'(rw1) == a) ||
                  (we0 && int'(rw0) == a);
        issued  = issue_en && int'(issue_rd) == a;
        return m_busy[a] && !(written && !issued);
    endfunction

    task automatic commit();
        bit wr;
        for (int i = 0; i < NR; i++) begin
            if (Reset) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end else if (i != PCR) begin
                wr = 1'b1;
                if (PCtoBL && i == LNK)          m_regs[i] = PC;
                else if (we1 && int'(rw1) == i)  m_regs[i] = wd1;
                else if (we0 && int'(rw0) == i)  m_regs[i] = wd0;
                else                             wr = 1'b0;
                if (issue_en && int'(issue_rd) == i) m_busy[i] = 1'b1;
                else if (wr)                         m_busy[i] = 1'b0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_rdA"},   rdA,          exp_rd(int'(ra)));
        check({tag, "_rdB"},   rdB,          exp_rd(int'(rb)));
        check({tag, "_busyA"}, DW'(busyA),   DW'(exp_busy(int'(ra))));
        check({tag, "_busyB"}, DW'(busyB),   DW'(exp_busy(int'(rb))));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        Reset = 0; we0 = 0; we1 = 0; PCtoBL = 0; issue_en = 0;
        rw0 = '0; rw1 = '0; wd0 = '0; wd1 = '0; issue_rd = '0;
    endtask

    // Advance one edge: the model commits on the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) < 6) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(28, 31));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        idle();
        ra = '0; rb = '0; PC = 64'h0000_0000_0000_1000;
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 'x;
            m_busy[i] = 1'bx;
        end
        #1;

        // Reset, then sweep every index while idle.
        Reset = 1;
        tick();
        idle();
        for (int a = 0; a < NR; a++) begin
            ra = AW'(a); rb = AW'(NR - 1 - a);
            #1;
            check("rst_rdA", rdA, (a == PCR) ? PC : '0);
            check("rst_busyA", DW'(busyA), '0);
            check_outputs("rst_sweep");
        end

        // Single write on port 0.
        tick();
        we0 = 1; rw0 = 5'd0; wd0 = 64'h4321_0000;
        tick();
        idle(); ra = 5'd0;
        #1;
        check("wr0_rdA", rdA, 64'h4321_0000);
        check("wr0_busyA", DW'(busyA), '0);

        // Port collision: port 1 wins, before and after the edge.
        we0 = 1; rw0 = 5'd1; wd0 = 64'h1111;
        we1 = 1; rw1 = 5'd1; wd1 = 64'h4321; rb = 5'd1;
        #1;
        check("coll_bypass_rdB", rdB, 64'h4321);
        tick();
        idle();
        #1;
        check("coll_commit_rdB", rdB, 64'h4321);

        // Link write beats port 1 on the link register. PC register reads PC.
        PC = 64'h1234_5678; PCtoBL = 1;
        we1 = 1; rw1 = 5'(LNK); wd1 = 64'hAAAA; ra = 5'(LNK);
        #1;
        check("link_bypass_rdA", rdA, 64'h1234_5678);
        ra = 5'(PCR);
        #1;
        check("pcreg_rdA", rdA, 64'h1234_5678);
        tick();
        idle(); ra = 5'(LNK);
        #1;
        check("link_commit_rdA", rdA, 64'h1234_5678);
        we0 = 1; rw0 = 5'(PCR); wd0 = 64'hDEAD_BEEF; ra = 5'(PCR);
        tick();
        idle(); PC = 64'h55;
        #1;
        check("pcreg_ignore_rdA", rdA, 64'h55);
        check("pcreg_busyA", DW'(busyA), '0);

        // Issue, write-back clearing, and re-issue in the write cycle.
        issue_en = 1; issue_rd = 5'd3; ra = 5'd3;
        tick();
        idle();
        #1;
        check("issue_busyA", DW'(busyA), 64'd1);
        we0 = 1; rw0 = 5'd3; wd0 = 64'h7;
        #1;
        check("wb_bypass_busyA", DW'(busyA), '0);
        tick();
        idle();
        #1;
        check("wb_commit_busyA", DW'(busyA), '0);
        issue_en = 1; issue_rd = 5'd3;
        tick();
        we0 = 1; rw0 = 5'd3; wd0 = 64'h8; issue_en = 1; issue_rd = 5'd3;
        tick();
        idle();
        #1;
        check("reissue_busyA", DW'(busyA), 64'd1);
        check("reissue_rdA", rdA, 64'h8);
        // Issue to an already-busy register keeps it busy.
        issue_en = 1; issue_rd = 5'd3;
        tick();
        idle();
        #1;
        check("waw_busyA", DW'(busyA), 64'd1);

        // Reset dominates a concurrent write and issue.
        we0 = 1; rw0 = 5'd2; wd0 = 64'h99;
        tick();
        idle(); issue_en = 1; issue_rd = 5'd2;
        tick();
        Reset = 1; we0 = 1; rw0 = 5'd2; wd0 = 64'h5;
        issue_en = 1; issue_rd = 5'd2; ra = 5'd2;
        tick();
        idle();
        #1;
        check("rst_dom_rdA", rdA, '0);
        check("rst_dom_busyA", DW'(busyA), '0);
        ra = 5'd3;
        #1;
        check("rst_drop_busy3", DW'(busyA), '0);

        // Randomized traffic compared against the model every cycle.
        for (int n = 0; n < 400; n++) begin
            tick();
            Reset    = ($urandom_range(0, 39) == 0);
            we0      = $urandom_range(0, 1);
            we1      = $urandom_range(0, 2) == 0;
            PCtoBL   = $urandom_range(0, 5) == 0;
            issue_en = $urandom_range(0, 2) == 0;
            rw0 = rand_addr(); rw1 = rand_addr(); issue_rd = rand_addr();
            ra  = rand_addr(); rb  = rand_addr();
            wd0 = {$urandom, $urandom}; wd1 = {$urandom, $urandom};
            PC  = {$urandom, $urandom};
            #2;
            check_outputs("rand");
        end

        // Final idle sweep of the stored state.
        tick();
        idle();
        for (int a = 0; a < NR; a++) begin
            ra = AW'(a); rb = AW'(a);
            #1;
            check_outputs("final");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
